multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle ARM processor (data-processing ADD/SUB/AND/ORR, LDR/STR with immediate offset, B). Decodes the 32-bit instruction held in the datapath's instruction register and sequences the shared datapath through a main FSM. Holds the NZCV condition flags and gates architectural writes with condition evaluation. Sits beside the datapath; inputs Instr and ALUFlags come from it, all outputs drive its muxes and enables.

Parameters:
none

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
Instr  in  32  current instruction
ALUFlags  in  4  {N,Z,C,V} from ALU this cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALU result
RegSrc  out  2  register-address selects
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=memory data, 10=ALU result direct
ImmSrc  out  2  immediate format
ALUControl  out  2  00=add, 01=sub, 10=and, 11=orr

Behaviour:
- Fields: Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20] (I=Funct[5], cmd=Instr[24:21], S/L=Funct[0]), Rd=Instr[15:12].
- Reset (sync): state<=FETCH, flags NZCV<=0000. In the cycle after reset deasserts, Fetch outputs are driven.
- FSM transitions: FETCH->DECODE; DECODE: Op=01->MEMADR, Op=00&I=0->EXECUTER, Op=00&I=1->EXECUTEI, Op=10->BRANCH, Op=11->FETCH; MEMADR: L=1->MEMREAD else MEMWRITE; MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH; EXECUTER/EXECUTEI->ALUWB. Illegal state->FETCH, with all FSM outputs 0.
- FSM outputs (unlisted = 0; ALUOp=0 unless listed):
  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  MEMADR: ALUSrcA=0, ALUSrcB=01.
  MEMREAD: AdrSrc=1, ResultSrc=00.
  MEMWB: ResultSrc=01, RegW=1.
  MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  ALUWB: ResultSrc=00, RegW=1.
  BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decoder: ALUOp=0 -> ALUControl=00, FlagW=00. ALUOp=1: cmd 0100->00, 0010->01, 0000->10, 1100->11, other->00; FlagW[1]=S; FlagW[0]=S&(cmd is ADD or SUB).
- ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01). Combinational from Instr in every state.
- PCS=((Rd==1111)&RegW)|Branch.
- CondEx: combinational from Cond and stored flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL(1110) 1, 1111 0.
- PCWrite=(PCS&CondEx)|NextPC; RegWrite=RegW&CondEx; MemWrite=MemW&CondEx. NextPC is not gated by CondEx.
- Flags: at rising edge, if FlagW[1]&CondEx then N,Z<=ALUFlags[3:2]; if FlagW[0]&CondEx then C,V<=ALUFlags[1:0]. This occurs only in EXECUTER/EXECUTEI. Reset has priority.
- Latencies in cycles: data-processing 4, LDR 5, STR 4, B 3.

Test Plan:
- Reset then Instr=E0821003 (ADD): FETCH IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10. DECODE, then EXECUTER ALUControl=00, ALUSrcB=00. ALUWB RegWrite=1, ResultSrc=00, PCWrite=0. Back to FETCH.
- Instr=E5921004 (LDR): MEMADR ALUSrcB=01, ImmSrc=01, RegSrc=10. MEMREAD AdrSrc=1. MEMWB RegWrite=1, ResultSrc=01.
- Instr=E5821004 (STR): MEMADR, then MEMWRITE MemWrite=1, AdrSrc=1, RegWrite=0. Next cycle FETCH.
- Instr=EA000001 (B): DECODE then BRANCH PCWrite=1, ALUSrcB=01, ImmSrc=10, RegSrc=01, ResultSrc=10.
- Instr=E0521003 (SUBS) with ALUFlags=0100 in EXECUTER (ALUControl=01) latches Z=1. Then Instr=00821003 (ADDEQ) gives ALUWB RegWrite=1. Repeat with ALUFlags=0000: RegWrite=0.
- Instr=E081F003 (ADD, Rd=PC): PCWrite=1 in ALUWB. Assert reset mid-LDR (MEMREAD): next cycle is FETCH and flags=0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath: main sequencing FSM, ALU
// decode, NZCV flag storage and conditional gating of architectural writes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FETCH     | read instruction at PC, load IR, PC <= PC + 4
// DECODE    | read register file, precompute PC + 8
// MEMADR    | compute load/store address (base + immediate)
// MEMREAD   | read data memory at computed address
// MEMWB     | write loaded word into the register file
// MEMWRITE  | write register data to memory
// EXECUTER  | data-processing op with register operand B
// EXECUTEI  | data-processing op with immediate operand B
// ALUWB     | write ALU result into the register file
// BRANCH    | PC <= PC + 8 + offset
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic       i_bit;
   logic       s_bit;
   logic [3:0] cmd;
   logic       rd_is_pc;

   logic       next_pc, branch, reg_w, mem_w, alu_op;
   logic [1:0] flag_w;
   logic       pcs, cond_ex;
   logic       n_q, z_q, c_q, v_q;

   // Operand fields the controller never looks at.
   logic       unused_instr_bits;

   assign cond     = Instr[31:28];
   assign op       = Instr[27:26];
   assign i_bit    = Instr[25];
   assign cmd      = Instr[24:21];
   assign s_bit    = Instr[20];
   assign rd_is_pc = (Instr[15:12] == 4'b1111);
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      state_d   = S_FETCH;
      next_pc   = 1'b0;
      branch    = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      alu_op    = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (state_q)
         S_FETCH: begin
            state_d   = S_DECODE;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = 1'b1;
            next_pc   = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (op)
               2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            state_d = S_MEMWB;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_w     = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         S_EXECUTER: begin
            state_d = S_ALUWB;
            alu_op  = 1'b1;
         end
         S_EXECUTEI: begin
            state_d = S_ALUWB;
            ALUSrcB = 2'b01;
            alu_op  = 1'b1;
         end
         S_ALUWB: begin
            reg_w = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // ALU operation select and flag-write enables for data-processing ops.
   always_comb begin
      ALUControl = 2'b00;
      flag_w     = 2'b00;
      if (alu_op) begin
         case (cmd)
            4'b0100: ALUControl = 2'b00;
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
            default: ALUControl = 2'b00;
         endcase
         flag_w[1] = s_bit;
         flag_w[0] = s_bit & ((cmd == 4'b0100) | (cmd == 4'b0010));
      end
   end

   // Condition check against the stored flags.
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = z_q;
         4'b0001: cond_ex = ~z_q;
         4'b0010: cond_ex = c_q;
         4'b0011: cond_ex = ~c_q;
         4'b0100: cond_ex = n_q;
         4'b0101: cond_ex = ~n_q;
         4'b0110: cond_ex = v_q;
         4'b0111: cond_ex = ~v_q;
         4'b1000: cond_ex = c_q & ~z_q;
         4'b1001: cond_ex = ~c_q | z_q;
         4'b1010: cond_ex = (n_q == v_q);
         4'b1011: cond_ex = (n_q != v_q);
         4'b1100: cond_ex = ~z_q & (n_q == v_q);
         4'b1101: cond_ex = z_q | (n_q != v_q);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // NZCV register; N/Z and C/V have independent write enables.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q <= 1'b0;
         z_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         if (flag_w[1] & cond_ex) begin
            n_q <= ALUFlags[3];
            z_q <= ALUFlags[2];
         end
         if (flag_w[0] & cond_ex) begin
            c_q <= ALUFlags[1];
            v_q <= ALUFlags[0];
         end
      end
   end

   // PC increment during fetch is unconditional; everything else is gated.
   assign pcs      = (rd_is_pc & reg_w) | branch;
   assign PCWrite  = (pcs & cond_ex) | next_pc;
   assign RegWrite = reg_w & cond_ex;
   assign MemWrite = mem_w & cond_ex;

   assign ImmSrc    = op;
   assign RegSrc[0] = (op == 2'b10);
   assign RegSrc[1] = (op == 2'b01);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction cycle-sequence model
// predicts every control output each cycle, for directed and random code.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   int checks   = 0;
   int failures = 0;

   // Model's copy of architectural flags {N,Z,C,V}.
   logic [3:0] m_flags;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         0:  return z;
         1:  return !z;
         2:  return cy;
         3:  return !cy;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return cy && !z;
         9:  return !cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Cycles an instruction occupies, by instruction class.
   function automatic int instr_len(input logic [31:0] ins);
      case (ins[27:26])
         2'b00:   return 4;
         2'b01:   return ins[20] ? 5 : 4;
         2'b10:   return 3;
         default: return 2;
      endcase
   endfunction

   // Expected outputs packed as
   // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
   function automatic logic [16:0] expect_out(input logic [31:0] ins, input int step,
                                               input logic [3:0] f);
      logic       pcw, mw, rw, irw, adr, srca;
      logic [1:0] regsrc, srcb, res, imm, aluc;
      logic [1:0] op;
      logic       ce, rdpc;
      logic [3:0] cmd;
      op   = ins[27:26];
      cmd  = ins[24:21];
      ce   = cond_ok(ins[31:28], f);
      rdpc = (ins[15:12] == 4'hF);
      pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; srca = 0;
      srcb = 0; res = 0; aluc = 0;
      imm    = op;
      regsrc = {op == 2'b01, op == 2'b10};
      if (step == 0) begin
         pcw = 1; irw = 1; srca = 1; srcb = 2; res = 2;
      end else if (step == 1) begin
         srca = 1; srcb = 2; res = 2;
      end else if (op == 2'b00) begin
         if (step == 2) begin
            srcb = ins[25] ? 2'd1 : 2'd0;
            if (cmd == 4) aluc = 0;
            else if (cmd == 2) aluc = 1;
            else if (cmd == 0) aluc = 2;
            else if (cmd == 12) aluc = 3;
            else aluc = 0;
         end else begin
            rw = ce; pcw = ce && rdpc;
         end
      end else if (op == 2'b01) begin
         if (step == 2) srcb = 1;
         else if (step == 3) begin
            adr = 1;
            mw  = !ins[20] && ce;
         end else begin
            res = 1; rw = ce; pcw = ce && rdpc;
         end
      end else if (op == 2'b10) begin
         srcb = 1; res = 2; pcw = ce;
      end
      return {pcw, mw, rw, irw, adr, regsrc, srca, srcb, res, imm, aluc};
   endfunction

   function automatic logic [16:0] dut_out();
      return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
              ALUSrcB, ResultSrc, ImmSrc, ALUControl};
   endfunction

   task automatic check(input string tag, input logic [31:0] ins, input int step,
                        input logic [16:0] obs, input logic [16:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s instr=%h step=%0d got=%h expected=%h", tag, ins, step, obs, exp);
      end
   endtask

   // Run one instruction cycle by cycle. fl_fixed >= 0 forces ALUFlags to that
   // value; otherwise random. reset_step >= 0 asserts reset during that step
   // and abandons the instruction there.
   task automatic run_instr(input string tag, input logic [31:0] ins,
                            input int fl_fixed, input int reset_step);
      int len;
      logic [3:0] af;
      logic ce;
      len = instr_len(ins);
      for (int s = 0; s < len; s++) begin
         @(negedge clk);
         af       = (fl_fixed >= 0) ? fl_fixed[3:0] : 4'($urandom_range(0, 15));
         Instr    = ins;
         ALUFlags = af;
         reset    = (s == reset_step);
         #1;
         check(tag, ins, s, dut_out(), expect_out(ins, s, m_flags));
         if (s == reset_step) begin
            m_flags = 4'b0000;
            return;
         end
         ce = cond_ok(ins[31:28], m_flags);
         if (s == 2 && ins[27:26] == 2'b00 && ins[20] && ce) begin
            m_flags[3:2] = af[3:2];
            if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010)
               m_flags[1:0] = af[1:0];
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      reset    = 1'b1;
      Instr    = 32'hE0821003;
      ALUFlags = 4'b0000;
      m_flags  = 4'b0000;
      repeat (2) @(negedge clk);
      #1;
      check("reset_fetch", Instr, 0, dut_out(), expect_out(Instr, 0, 4'b0000));

      run_instr("add",      32'hE0821003, -1, -1);
      run_instr("ldr",      32'hE5921004, -1, -1);
      run_instr("str",      32'hE5821004, -1, -1);
      run_instr("b",        32'hEA000001, -1, -1);
      run_instr("subs_z1",  32'hE0521003, 4,  -1);
      run_instr("addeq_t",  32'h00821003, -1, -1);
      run_instr("subs_z0",  32'hE0521003, 0,  -1);
      run_instr("addeq_f",  32'h00821003, -1, -1);
      run_instr("add_pc",   32'hE081F003, -1, -1);
      run_instr("subs_z1b", 32'hE0521003, 4,  -1);
      run_instr("bne_nt",   32'h1A000001, -1, -1);
      run_instr("ldr_rst",  32'hE5921004, -1, 3);
      run_instr("addeq_rst",32'h00821003, -1, -1);
      run_instr("op11",     32'hEC000000, -1, -1);
      run_instr("nv_str",   32'hF5821004, -1, -1);

      for (int k = 0; k < 300; k++) begin
         r = $urandom;
         if ($urandom_range(0, 3) == 0) r[31:28] = 4'hE;
         if (r[27:26] == 2'b00 && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
               0: r[24:21] = 4'b0100;
               1: r[24:21] = 4'b0010;
               2: r[24:21] = 4'b0000;
               default: r[24:21] = 4'b1100;
            endcase
         end
         if ($urandom_range(0, 7) == 0) r[15:12] = 4'hF;
         run_instr("random", r, -1, ($urandom_range(0, 29) == 0) ? 2 : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
